// File: rtl/stream_framer.sv
// Overlapping-frame builder: buffers a PCM stream in a circular RAM and replays
// FRAME_LEN-sample windows every HOP_LEN samples, with sop/eop markers and end-of-stream flush.
module stream_framer #(
  parameter int DATA_BW   = 14,
  parameter int FRAME_LEN = 1024,
  parameter int HOP_LEN   = 160,
  parameter int BUF_DEPTH = 2048,
  parameter int PAD_MODE  = 1,
  parameter int FIDX_BW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [DATA_BW-1:0] i_data,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [DATA_BW-1:0] o_data,
  output logic               o_sop,
  output logic               o_eop,
  output logic [FIDX_BW-1:0] o_frame_idx,
  output logic               o_flush_done
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(FRAME_LEN + 1);

  localparam logic [CW-1:0]      FRAME_C  = CW'(FRAME_LEN);
  localparam logic [CW-1:0]      HOP_C    = CW'(HOP_LEN);
  localparam logic [CW-1:0]      DEPTH_C  = CW'(BUF_DEPTH);
  localparam logic [CW-1:0]      THRESH_C = CW'(FRAME_LEN - HOP_LEN);
  localparam logic [CW-1:0]      ONE_C    = CW'(1'b1);
  localparam logic [AW-1:0]      ONE_A    = AW'(1'b1);
  localparam logic [AW-1:0]      HOP_A    = AW'(HOP_LEN);
  localparam logic [RW-1:0]      ONE_R    = RW'(1'b1);
  localparam logic [RW-1:0]      LAST_OFF = RW'(FRAME_LEN - 1);
  localparam logic [RW-1:0]      END_OFF  = RW'(FRAME_LEN);
  localparam logic [FIDX_BW-1:0] ONE_F    = FIDX_BW'(1'b1);

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    EMIT       = 2'd1,
    FLUSH_EMIT = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t             state_r;
  logic [DATA_BW-1:0] buf_mem [BUF_DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      base_ptr_r;
  logic [CW-1:0]      count_r;
  logic [RW-1:0]      rd_off_r;
  logic               first_done_r;
  logic               flush_pend_r;

  logic               wr_en_s;
  logic               emitting_s;
  logic               load_s;
  logic               eop_hs_s;
  logic               flush_now_s;
  logic [CW-1:0]      cnt_wr_s;
  logic [CW-1:0]      hop_amt_s;
  logic [CW-1:0]      cnt_hop_s;
  logic [AW-1:0]      base_hop_s;
  logic [AW-1:0]      rd_addr_s;
  logic               pad_s;

  // A trailing partial frame is worth emitting if it holds samples no earlier frame covered.
  function automatic logic flush_cond(input logic [CW-1:0] cnt, input logic first);
    return (PAD_MODE == 1) && ((cnt > THRESH_C) || (!first && (cnt != {CW{1'b0}})));
  endfunction

  // Handshake qualifiers and next-count arithmetic shared by the FSM.
  always_comb begin
    wr_en_s     = i_valid && i_ready;
    emitting_s  = (state_r == EMIT) || (state_r == FLUSH_EMIT);
    load_s      = emitting_s && (rd_off_r != END_OFF) && (!o_valid || o_ready);
    eop_hs_s    = emitting_s && o_valid && o_ready && o_eop;
    flush_now_s = i_flush || flush_pend_r;
    if (wr_en_s) begin
      cnt_wr_s = count_r + ONE_C;
    end else begin
      cnt_wr_s = count_r;
    end
    if (count_r < HOP_C) begin
      hop_amt_s = count_r;
    end else begin
      hop_amt_s = HOP_C;
    end
    cnt_hop_s  = cnt_wr_s - hop_amt_s;
    base_hop_s = base_ptr_r + HOP_A;
    rd_addr_s  = base_ptr_r + AW'(rd_off_r);
    pad_s      = (state_r == FLUSH_EMIT) && (CW'(rd_off_r) >= count_r);
  end

  // Sample storage; never overwrites unreleased entries because writes stop at count == BUF_DEPTH.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buf_mem[wr_ptr_r] <= i_data;
    end
  end

  // Framing FSM with registered output stage; the eop handshake either chains straight into the next frame or leaves EMIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= FILL;
      wr_ptr_r     <= {AW{1'b0}};
      base_ptr_r   <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      rd_off_r     <= {RW{1'b0}};
      first_done_r <= 1'b0;
      flush_pend_r <= 1'b0;
      i_ready      <= 1'b0;
      o_valid      <= 1'b0;
      o_data       <= {DATA_BW{1'b0}};
      o_sop        <= 1'b0;
      o_eop        <= 1'b0;
      o_frame_idx  <= {FIDX_BW{1'b0}};
      o_flush_done <= 1'b0;
    end else begin
      o_flush_done <= 1'b0;
      i_ready      <= (cnt_wr_s < DEPTH_C);
      count_r      <= cnt_wr_s;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_A;
      end
      case (state_r)
        FILL: begin
          rd_off_r <= {RW{1'b0}};
          if (count_r >= FRAME_C) begin
            state_r      <= EMIT;
            flush_pend_r <= flush_now_s;
          end else if (flush_now_s && (cnt_wr_s < FRAME_C)) begin
            flush_pend_r <= 1'b0;
            i_ready      <= 1'b0;
            if (flush_cond(cnt_wr_s, first_done_r)) begin
              state_r <= FLUSH_EMIT;
            end else begin
              state_r <= DONE;
            end
          end else begin
            flush_pend_r <= flush_now_s;
          end
        end
        EMIT, FLUSH_EMIT: begin
          if (state_r == FLUSH_EMIT) begin
            flush_pend_r <= 1'b0;
            i_ready      <= 1'b0;
          end else begin
            flush_pend_r <= flush_now_s;
          end
          if (load_s) begin
            o_valid  <= 1'b1;
            o_data   <= pad_s ? {DATA_BW{1'b0}} : buf_mem[rd_addr_s];
            o_sop    <= (rd_off_r == {RW{1'b0}});
            o_eop    <= (rd_off_r == LAST_OFF);
            rd_off_r <= rd_off_r + ONE_R;
          end else if (eop_hs_s) begin
            base_ptr_r   <= base_hop_s;
            count_r      <= cnt_hop_s;
            o_frame_idx  <= o_frame_idx + ONE_F;
            first_done_r <= 1'b1;
            if ((state_r == EMIT) && (cnt_hop_s >= FRAME_C)) begin
              o_valid  <= 1'b1;
              o_data   <= buf_mem[base_hop_s];
              o_sop    <= 1'b1;
              o_eop    <= 1'b0;
              rd_off_r <= ONE_R;
              i_ready  <= (cnt_hop_s < DEPTH_C);
            end else begin
              o_valid  <= 1'b0;
              o_sop    <= 1'b0;
              o_eop    <= 1'b0;
              rd_off_r <= {RW{1'b0}};
              if ((state_r == EMIT) && !flush_now_s) begin
                state_r <= FILL;
                i_ready <= (cnt_hop_s < DEPTH_C);
              end else begin
                flush_pend_r <= 1'b0;
                i_ready      <= 1'b0;
                if (flush_cond(cnt_hop_s, 1'b1)) begin
                  state_r <= FLUSH_EMIT;
                end else begin
                  state_r <= DONE;
                end
              end
            end
          end else if (o_ready) begin
            o_valid <= 1'b0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
          end
        end
        DONE: begin
          wr_ptr_r     <= {AW{1'b0}};
          base_ptr_r   <= {AW{1'b0}};
          count_r      <= {CW{1'b0}};
          rd_off_r     <= {RW{1'b0}};
          first_done_r <= 1'b0;
          flush_pend_r <= 1'b0;
          o_flush_done <= 1'b1;
          i_ready      <= 1'b1;
          state_r      <= FILL;
        end
        default: begin
          state_r <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_framer.sv
// Directed bench for stream_framer: three instances (hop 3 pad, hop 3 drop, hop 8) share
// one stimulus port selected by sel; outputs are captured and compared against hand-built frames.
module tb_stream_framer;
  localparam int DW = 14;
  localparam int FW = 16;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] sel;
  logic i_valid, i_flush, o_ready;
  logic [DW-1:0] i_data;

  logic          ir   [3];
  logic          ov   [3];
  logic [DW-1:0] od   [3];
  logic          sp   [3];
  logic          ep   [3];
  logic [FW-1:0] fidx [3];
  logic          fd   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    stream_framer #(
      .DATA_BW(DW), .FRAME_LEN(8), .HOP_LEN(g == 2 ? 8 : 3),
      .BUF_DEPTH(16), .PAD_MODE(g == 1 ? 0 : 1), .FIDX_BW(FW)
    ) u_dut (
      .clk(clk), .rst(rst),
      .i_valid(i_valid && (sel == 2'(g))), .i_ready(ir[g]), .i_data(i_data),
      .i_flush(i_flush && (sel == 2'(g))),
      .o_valid(ov[g]), .o_ready((sel == 2'(g)) ? o_ready : 1'b1), .o_data(od[g]),
      .o_sop(sp[g]), .o_eop(ep[g]), .o_frame_idx(fidx[g]), .o_flush_done(fd[g])
    );
  end

  logic          obs_ir, obs_ov, obs_sp, obs_ep, obs_fd;
  logic [DW-1:0] obs_od;
  logic [FW-1:0] obs_idx;
  assign obs_ir  = (sel == 2'd0) ? ir[0]   : (sel == 2'd1) ? ir[1]   : ir[2];
  assign obs_ov  = (sel == 2'd0) ? ov[0]   : (sel == 2'd1) ? ov[1]   : ov[2];
  assign obs_od  = (sel == 2'd0) ? od[0]   : (sel == 2'd1) ? od[1]   : od[2];
  assign obs_sp  = (sel == 2'd0) ? sp[0]   : (sel == 2'd1) ? sp[1]   : sp[2];
  assign obs_ep  = (sel == 2'd0) ? ep[0]   : (sel == 2'd1) ? ep[1]   : ep[2];
  assign obs_idx = (sel == 2'd0) ? fidx[0] : (sel == 2'd1) ? fidx[1] : fidx[2];
  assign obs_fd  = (sel == 2'd0) ? fd[0]   : (sel == 2'd1) ? fd[1]   : fd[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int  cap_d[$], cap_s[$], cap_e[$], cap_i[$], cap_c[$];
  int  cyc = 0;
  int  fd_cnt = 0, rdy_viol = 0, full_seen = 0;
  bit  rand_ready = 1'b0, flush_watch = 1'b0;
  bit  prev_stall = 1'b0;
  int  prev_d, prev_s, prev_e, prev_i;

  // Output monitor: drives o_ready, records accepted samples and checks hold-while-stalled.
  initial begin
    o_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        check_eq("hold_valid", int'(obs_ov), 1);
        check_eq("hold_data", int'(obs_od), prev_d);
        check_eq("hold_sop", int'(obs_sp), prev_s);
        check_eq("hold_eop", int'(obs_ep), prev_e);
        check_eq("hold_idx", int'(obs_idx), prev_i);
      end
      o_ready = rand_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (rst && obs_ov && obs_ir && flush_watch && cap_d.size() >= 16) rdy_viol++;
      if (rst && obs_ov && o_ready) begin
        cap_d.push_back(int'(obs_od));
        cap_s.push_back(int'(obs_sp));
        cap_e.push_back(int'(obs_ep));
        cap_i.push_back(int'(obs_idx));
        cap_c.push_back(cyc);
      end
      if (rst && obs_fd) fd_cnt++;
      if (rst && i_valid && !obs_ir) full_seen++;
      prev_stall = rst && obs_ov && !o_ready;
      prev_d = int'(obs_od);
      prev_s = int'(obs_sp);
      prev_e = int'(obs_ep);
      prev_i = int'(obs_idx);
    end
  end

  task automatic clear_caps();
    cap_d.delete(); cap_s.delete(); cap_e.delete(); cap_i.delete(); cap_c.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_caps();
    fd_cnt = 0; rdy_viol = 0; full_seen = 0;
  endtask

  task automatic send_ramp(input int first, input int last);
    for (int v = first; v <= last; v++) begin
      int guard = 0;
      i_valid = 1'b1;
      i_data  = DW'(v);
      while (!obs_ir && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) begin
        check_eq("send_timeout", guard, 0);
        break;
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
  endtask

  task automatic wait_caps(input string tag, input int n, input int budget);
    int c = 0;
    while (cap_d.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (6) @(negedge clk);
    check_eq({tag, "_count"}, cap_d.size(), n);
  endtask

  task automatic check_frame(input string tag, input int q0, input int first_val,
                             input int fidx_exp, input int nvalid);
    for (int j = 0; j < 8; j++) begin
      if (q0 + j < cap_d.size()) begin
        check_eq($sformatf("%s_data[%0d]", tag, j), cap_d[q0+j], (j < nvalid) ? first_val + j : 0);
        check_eq($sformatf("%s_sop[%0d]", tag, j), cap_s[q0+j], (j == 0) ? 1 : 0);
        check_eq($sformatf("%s_eop[%0d]", tag, j), cap_e[q0+j], (j == 7) ? 1 : 0);
        check_eq($sformatf("%s_idx[%0d]", tag, j), cap_i[q0+j], fidx_exp);
      end else begin
        check_eq($sformatf("%s_missing[%0d]", tag, j), cap_d.size(), q0 + j + 1);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_i_ready"}, int'(obs_ir), 0);
    check_eq({tag, "_o_valid"}, int'(obs_ov), 0);
    check_eq({tag, "_o_data"}, int'(obs_od), 0);
    check_eq({tag, "_o_sop"}, int'(obs_sp), 0);
    check_eq({tag, "_o_eop"}, int'(obs_ep), 0);
    check_eq({tag, "_o_frame_idx"}, int'(obs_idx), 0);
    check_eq({tag, "_o_flush_done"}, int'(obs_fd), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got time %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    sel = 2'd0; rst = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_data = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");

    // Continuous ramp, three overlapping frames.
    do_reset();
    send_ramp(1, 14);
    wait_caps("s1", 24, 200);
    check_frame("s1_f0", 0, 1, 0, 8);
    check_frame("s1_f1", 8, 4, 1, 8);
    check_frame("s1_f2", 16, 7, 2, 8);

    // Flush with zero padding.
    do_reset();
    flush_watch = 1'b1;
    send_ramp(1, 12);
    pulse_flush();
    wait_caps("s2", 24, 300);
    flush_watch = 1'b0;
    check_frame("s2_f0", 0, 1, 0, 8);
    check_frame("s2_f1", 8, 4, 1, 8);
    check_frame("s2_f2", 16, 7, 2, 6);
    check_eq("s2_flush_done", fd_cnt, 1);
    check_eq("s2_ready_in_flush", rdy_viol, 0);

    // Flush dropping the tail, then a fresh stream.
    sel = 2'd1;
    do_reset();
    send_ramp(1, 12);
    pulse_flush();
    wait_caps("s3", 16, 300);
    check_frame("s3_f0", 0, 1, 0, 8);
    check_frame("s3_f1", 8, 4, 1, 8);
    check_eq("s3_flush_done", fd_cnt, 1);
    clear_caps();
    send_ramp(1, 8);
    wait_caps("s3_fresh", 8, 200);
    check_frame("s3_fresh", 0, 1, 2, 8);

    // Random downstream backpressure over a long ramp.
    sel = 2'd0;
    do_reset();
    rand_ready = 1'b1;
    send_ramp(1, 100);
    wait_caps("s4", 248, 4000);
    rand_ready = 1'b0;
    for (int k = 0; k < 31; k++) begin
      check_frame($sformatf("s4_f%0d", k), 8 * k, 3 * k + 1, k, 8);
    end
    check_eq("s4_input_backpressure", int'(full_seen > 0), 1);

    // Reset in the middle of a frame.
    do_reset();
    send_ramp(1, 8);
    begin
      int c = 0;
      while (cap_d.size() < 4 && c < 200) begin
        @(negedge clk);
        c++;
      end
      check_eq("s5_reach_mid", int'(cap_d.size() >= 4), 1);
    end
    rst = 1'b0;
    #1;
    check_idle_outputs("s5_async");
    for (int q = 0; q < cap_e.size(); q++) check_eq("s5_no_eop", cap_e[q], 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_caps();
    send_ramp(1, 8);
    wait_caps("s5_after", 8, 200);
    check_frame("s5_after", 0, 1, 0, 8);

    // Non-overlapping frames, back to back.
    sel = 2'd2;
    do_reset();
    send_ramp(1, 16);
    wait_caps("s6", 16, 300);
    check_frame("s6_f0", 0, 1, 0, 8);
    check_frame("s6_f1", 8, 9, 1, 8);
    if (cap_c.size() >= 9) begin
      check_eq("s6_back_to_back", cap_c[8] - cap_c[7], 1);
    end else begin
      check_eq("s6_back_to_back_samples", cap_c.size(), 16);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
